bouncing_sprite_gen: RTL
========================

BOUNCING_SPRITE_GEN -- requirements
Module: bouncing_sprite_gen

Interface
REQ-001 SHALL have parameter N_SPRITES, default 4, number of sprites (1..8).
REQ-002 SHALL have parameter SIZE, default 4, sprite edge length in pixels (square).
REQ-003 SHALL have parameter SPEED, default 2, initial per-frame step magnitude in pixels (1..SIZE).
REQ-004 SHALL have parameter H_ACTIVE, default 640, visible columns.
REQ-005 SHALL have parameter V_ACTIVE, default 480, visible rows.
REQ-006 SHALL have port clk_i, input, 1, pixel clock; the only clock.
REQ-007 SHALL have port reset_ni, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port run_i, input, 1, 1 = sprites advance each frame, 0 = frozen.
REQ-009 SHALL have port vsync_i, input, 1, vertical sync from the VGA driver, synchronous to clk_i.
REQ-010 SHALL have port hpos_i, input, 16, current pixel column.
REQ-011 SHALL have port vpos_i, input, 16, current pixel row.
REQ-012 SHALL have port bg_i, input, 16, RGB565 background colour.
REQ-013 SHALL have port rgb_o, output, 16, RGB565 pixel to the VGA driver.
REQ-014 SHALL have port collide_o, output, 1, sticky: two or more sprites overlapped a pixel this frame.
REQ-015 SHALL have port frame_done_o, output, 1, one-cycle pulse when the position update completes.

Function
REQ-016 SHALL detect the vsync_i rising edge with a registered copy of vsync_i; this edge is "frame tick".
REQ-017 SHALL implement FSM IDLE/UPDATE: IDLE -> UPDATE on frame tick with run_i=1, index=0; UPDATE handles sprite[index], one per cycle; after index N_SPRITES-1 -> IDLE and frame_done_o=1 for that single cycle.
REQ-018 SHALL ignore frame ticks while in UPDATE; frame tick with run_i=0 leaves state and positions unchanged and produces no frame_done_o.
REQ-019 SHALL store per sprite x, y (16-bit unsigned) and vx, vy (signed, magnitude SPEED).
REQ-020 Horizontal update SHALL be: vx>0 and x+vx > H_ACTIVE-SIZE -> x=H_ACTIVE-SIZE, vx=-vx; vx<0 and x < |vx| -> x=0, vx=-vx; else x=x+vx.
REQ-021 Vertical update SHALL follow REQ-020 using y, vy and V_ACTIVE; horizontal and vertical bounces in the same update (corner) SHALL both apply.
REQ-022 Sprite k SHALL be hit when x_k <= hpos_i < x_k+SIZE and y_k <= vpos_i < y_k+SIZE; comparisons SHALL be 17-bit so no wrap occurs.
REQ-023 rgb_o SHALL be registered, 1-cycle latency from hpos_i/vpos_i: colour of lowest-index hit sprite, else bg_i.
REQ-024 Colour table by k: 0 FFFF, 1 F800, 2 07E0, 3 001F, 4 FFE0, 5 F81F, 6 07FF, 7 FC00.
REQ-025 collide_o SHALL set on a clk_i edge where two or more sprites are hit, hold until the next frame tick, and clear on that frame tick unless a collision occurs in the same cycle (set wins).
REQ-026 Position updates during UPDATE SHALL affect hit detection from the next cycle on; no pixel output is blanked during UPDATE.

Reset
REQ-027 On reset_ni=0, asynchronously: state IDLE, index 0, rgb_o=0000, collide_o=0, frame_done_o=0, vsync register 0.
REQ-028 On reset, sprite k SHALL load x=64+32k, y=64+24k, vx=+SPEED for even k and -SPEED for odd k, vy=+SPEED.
REQ-029 Reset asserted mid-UPDATE SHALL abort the update; after release the block SHALL wait in IDLE for the next frame tick.

Verification
REQ-030 Reset release, run_i=1, one frame tick -> frame_done_o pulses exactly N_SPRITES+1 cycles after the vsync_i rise; sprite0 (66,66), sprite1 (94,90).
REQ-031 Sprite0 forced to x=634, vx=+2, SIZE=4 -> after tick x=636, vx=+2; next tick x=636, vx=-2; next tick x=634.
REQ-032 Sprite0 at (1,1), vx=vy=-2 -> after tick (0,0), vx=vy=+2 (corner bounce).
REQ-033 hpos_i=64, vpos_i=64 after reset -> rgb_o=FFFF one cycle later; hpos_i=68 -> rgb_o=bg_i.
REQ-034 Sprites 0 and 1 both placed at (100,100), pixel (101,101) driven -> rgb_o=FFFF, collide_o=1 until next frame tick, then 0.
REQ-035 run_i=0 for three frame ticks -> positions unchanged, frame_done_o never pulses; reset_ni pulsed mid-UPDATE -> REQ-028 positions restored, rgb_o=0000.

Source files
------------

// File: rtl/bouncing_sprite_gen.sv
// Bouncing sprite generator: N square sprites that move one step per frame,
// bounce off the active-area edges and are overlaid on a background pixel stream.
module bouncing_sprite_gen #(
   parameter int N_SPRITES = 4,
   parameter int SIZE      = 4,
   parameter int SPEED     = 2,
   parameter int H_ACTIVE  = 640,
   parameter int V_ACTIVE  = 480
) (
   input  logic        clk_i,
   input  logic        reset_ni,
   input  logic        run_i,
   input  logic        vsync_i,
   input  logic [15:0] hpos_i,
   input  logic [15:0] vpos_i,
   input  logic [15:0] bg_i,
   output logic [15:0] rgb_o,
   output logic        collide_o,
   output logic        frame_done_o
);

   localparam logic [16:0] X_LIMIT  = 17'(H_ACTIVE - SIZE);
   localparam logic [16:0] Y_LIMIT  = 17'(V_ACTIVE - SIZE);
   localparam logic [16:0] EDGE     = 17'(SIZE);
   localparam logic [2:0]  LAST_IDX = 3'(N_SPRITES - 1);

   typedef enum logic {IDLE, UPDATE} state_t;

   typedef struct packed {
      logic [15:0]        pos;
      logic signed [15:0] vel;
   } axis_t;

   // One axis of motion: clamp to the wall and reverse direction when the
   // step would leave [0, limit].
   function automatic axis_t stepAxis(input logic [15:0] pos,
                                      input logic signed [15:0] vel,
                                      input logic [16:0] limit);
      axis_t       r;
      logic [15:0] mag;
      logic [16:0] sum;
      mag   = vel[15] ? 16'(-vel) : 16'(vel);
      sum   = {1'b0, pos} + {1'b0, mag};
      r.pos = pos;
      r.vel = vel;
      if (!vel[15]) begin
         if (sum > limit) begin
            r.pos = limit[15:0];
            r.vel = -vel;
         end else begin
            r.pos = sum[15:0];
         end
      end else if (pos < mag) begin
         r.pos = 16'd0;
         r.vel = -vel;
      end else begin
         r.pos = pos - mag;
      end
      return r;
   endfunction

   function automatic logic [15:0] spriteColour(input int k);
      case (k)
         0:       spriteColour = 16'hFFFF;
         1:       spriteColour = 16'hF800;
         2:       spriteColour = 16'h07E0;
         3:       spriteColour = 16'h001F;
         4:       spriteColour = 16'hFFE0;
         5:       spriteColour = 16'hF81F;
         6:       spriteColour = 16'h07FF;
         default: spriteColour = 16'hFC00;
      endcase
   endfunction

   state_t             state_q, state_d;
   logic [2:0]         index_q, index_d;
   logic               vsync_q;
   logic               frameTick;
   logic               frame_done_q, frame_done_d;
   logic [15:0]        rgb_q, rgb_d;
   logic               collide_q, collide_d;
   logic [3:0]         hitCount;

   logic [15:0]        x_q  [N_SPRITES];
   logic [15:0]        y_q  [N_SPRITES];
   logic signed [15:0] vx_q [N_SPRITES];
   logic signed [15:0] vy_q [N_SPRITES];

   logic [15:0]        curX, curY;
   logic signed [15:0] curVx, curVy;
   axis_t              nextX, nextY;

   assign frameTick = vsync_i & ~vsync_q;

   always_comb begin
      state_d      = state_q;
      index_d      = index_q;
      frame_done_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (frameTick && run_i) begin
               state_d = UPDATE;
               index_d = 3'd0;
            end
         end
         UPDATE: begin
            if (index_q == LAST_IDX) begin
               state_d      = IDLE;
               index_d      = 3'd0;
               frame_done_d = 1'b1;
            end else begin
               index_d = index_q + 3'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q      <= IDLE;
         index_q      <= 3'd0;
         vsync_q      <= 1'b0;
         frame_done_q <= 1'b0;
         rgb_q        <= 16'h0000;
         collide_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         index_q      <= index_d;
         vsync_q      <= vsync_i;
         frame_done_q <= frame_done_d;
         rgb_q        <= rgb_d;
         collide_q    <= collide_d;
      end
   end

   // A single shared step unit serves whichever sprite the index selects.
   always_comb begin
      curX  = 16'd0;
      curY  = 16'd0;
      curVx = 16'sd0;
      curVy = 16'sd0;
      for (int k = 0; k < N_SPRITES; k++) begin
         if (index_q == 3'(k)) begin
            curX  = x_q[k];
            curY  = y_q[k];
            curVx = vx_q[k];
            curVy = vy_q[k];
         end
      end
      nextX = stepAxis(curX, curVx, X_LIMIT);
      nextY = stepAxis(curY, curVy, Y_LIMIT);
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         for (int k = 0; k < N_SPRITES; k++) begin
            x_q[k]  <= 16'(64 + 32 * k);
            y_q[k]  <= 16'(64 + 24 * k);
            vx_q[k] <= (k % 2 == 0) ? 16'(SPEED) : 16'(-SPEED);
            vy_q[k] <= 16'(SPEED);
         end
      end else if (state_q == UPDATE) begin
         for (int k = 0; k < N_SPRITES; k++) begin
            if (index_q == 3'(k)) begin
               x_q[k]  <= nextX.pos;
               y_q[k]  <= nextY.pos;
               vx_q[k] <= nextX.vel;
               vy_q[k] <= nextY.vel;
            end
         end
      end
   end

   // Scanning from the top index down lets the lowest-index hit win the colour.
   always_comb begin
      rgb_d    = bg_i;
      hitCount = 4'd0;
      for (int k = N_SPRITES - 1; k >= 0; k--) begin
         if (({1'b0, hpos_i} >= {1'b0, x_q[k]}) &&
             ({1'b0, hpos_i} <  ({1'b0, x_q[k]} + EDGE)) &&
             ({1'b0, vpos_i} >= {1'b0, y_q[k]}) &&
             ({1'b0, vpos_i} <  ({1'b0, y_q[k]} + EDGE))) begin
            rgb_d    = spriteColour(k);
            hitCount = hitCount + 4'd1;
         end
      end
      collide_d = (hitCount > 4'd1) | (collide_q & ~frameTick);
   end

   assign rgb_o        = rgb_q;
   assign collide_o    = collide_q;
   assign frame_done_o = frame_done_q;

endmodule
